// File: rtl/ahb_apb_pkg.sv
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Shared types and constants for the AHB-to-APB bridge
//               controller: FSM state encoding, HRESP codes and the default
//               widths used by the bridge.
// Revision    : 1.0 - initial second-generation release
// ============================================================================
`default_nettype none

package ahb_apb_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    // AHB response codes
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Default geometry
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_SLV     = 3;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage : ahb_apb_pkg

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// Module      : apb_wait_timer
// Description : Counts APB ACCESS wait cycles and flags the terminal count.
//               tc is raised in the ACCESS cycle that would make the
//               TIMEOUT_CYC-th consecutive wait, so the FSM leaves on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic Hclk,
    input  logic Hresetn,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    // Wait counter: cleared on ACCESS entry, advances on each stalled cycle
    always_ff @(posedge Hclk) begin
        if (!Hresetn || clear) begin
            r_cnt <= '0;
        end else if (enable && !tc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tc = enable && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule : apb_wait_timer

`default_nettype wire

// File: rtl/ahb2apb_bridge_ctrl_p.sv
// ============================================================================
// Module      : ahb2apb_bridge_ctrl_p
// Description : Second-generation AHB-to-APB bridge controller. Converts one
//               qualified AHB transfer at a time into an APB SETUP/ACCESS
//               cycle with PREADY wait states, PSLVERR and decode-error
//               two-cycle ERROR responses. All outputs are registered.
//               Optional ACCESS timeout enabled by macro APB_TIMEOUT_EN.
// Revision    : 1.0 - initial second-generation release
// ============================================================================
`default_nettype none

module ahb2apb_bridge_ctrl_p
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_SLV     = DEF_NUM_SLV,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [NUM_SLV-1:0] Hselx_dec,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic              Hreadyout,
    output logic              Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic [NUM_SLV-1:0] Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);

    state_t             r_state;
    state_t             w_next;
    logic [NUM_SLV-1:0] r_sel;
    logic [NUM_SLV-1:0] w_sel;
    logic               w_onehot;
    logic               w_accept;
    logic               w_tc;

    assign w_onehot = ($countones(Hselx_dec) == 1);
    assign w_accept = (r_state == ST_IDLE) && valid && w_onehot;
    // A read goes straight to SETUP, so the select must come from the decoder
    assign w_sel    = (r_state == ST_IDLE) ? Hselx_dec : r_sel;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .clear   (r_state == ST_SETUP),
        .enable  ((r_state == ST_ACCESS) && !Pready),
        .tc      (w_tc)
    );
`else
    // No counter: ACCESS never times out; the parameter only keeps the
    // interface identical between builds.
    assign w_tc = (TIMEOUT_CYC < 0);
`endif

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (valid) begin
                    if (!w_onehot)   w_next = ST_ERR1;
                    else if (Hwrite) w_next = ST_WWAIT;
                    else             w_next = ST_SETUP;
                end
            end
            ST_WWAIT:  w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: begin
                if (Pready)    w_next = Pslverr ? ST_ERR1 : ST_IDLE;
                else if (w_tc) w_next = ST_ERR1;
            end
            ST_ERR1:   w_next = ST_ERR2;
            ST_ERR2:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State, Moore-decoded control outputs and datapath capture registers
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
            Hrdata    <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
        end else begin
            r_state   <= w_next;
            Hreadyout <= (w_next == ST_IDLE) || (w_next == ST_ERR2);
            Hresp     <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ?
                         HRESP_ERROR : HRESP_OKAY;
            Pselx     <= ((w_next == ST_SETUP) || (w_next == ST_ACCESS)) ?
                         w_sel : '0;
            Penable   <= (w_next == ST_ACCESS);

            if (w_accept) begin
                r_sel  <= Hselx_dec;
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
            end
            if (r_state == ST_WWAIT) begin
                Pwdata <= Hwdata;
            end
            if ((r_state == ST_ACCESS) && Pready && !Pslverr && !Pwrite) begin
                Hrdata <= Prdata;
            end
        end
    end

endmodule : ahb2apb_bridge_ctrl_p

`default_nettype wire

// File: tb/tb_ahb2apb_bridge_ctrl_p.sv
// ============================================================================
// Module      : tb_ahb2apb_bridge_ctrl_p
// Description : Self-checking bench for ahb2apb_bridge_ctrl_p. Builds the
//               expected cycle timeline of each transfer from its latency
//               rules and compares every output each cycle.
//               Honours APB_TIMEOUT_EN (TIMEOUT_CYC = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ahb2apb_bridge_ctrl_p;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int TO = 4;

    logic          Hclk = 1'b0;
    logic          Hresetn;
    logic          valid;
    logic [AW-1:0] Haddr;
    logic          Hwrite;
    logic [DW-1:0] Hwdata;
    logic [NS-1:0] Hselx_dec;
    logic [DW-1:0] Prdata;
    logic          Pready;
    logic          Pslverr;
    logic          Hreadyout;
    logic          Hresp;
    logic [DW-1:0] Hrdata;
    logic [NS-1:0] Pselx;
    logic          Penable;
    logic          Pwrite;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] m_hrdata;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [NS-1:0] sel;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        logic          serr;
        logic [DW-1:0] exp_hrdata;
    } vec_t;

    ahb2apb_bridge_ctrl_p #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .NUM_SLV     (NS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Hwdata    (Hwdata),
        .Hselx_dec (Hselx_dec),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".Hreadyout"}, 64'(Hreadyout), 64'd1);
        chk({tag, ".Hresp"},     64'(Hresp),     64'd0);
        chk({tag, ".Pselx"},     64'(Pselx),     64'd0);
        chk({tag, ".Penable"},   64'(Penable),   64'd0);
        chk({tag, ".Pwrite"},    64'(Pwrite),    64'd0);
        chk({tag, ".Paddr"},     64'(Paddr),     64'd0);
        chk({tag, ".Pwdata"},    64'(Pwdata),    64'd0);
        chk({tag, ".Hrdata"},    64'(Hrdata),    64'd0);
    endtask

    // Transfer outcome: decode error, slave error or (optionally) timeout
    function automatic bit txn_err(input vec_t v);
        bit e;
        e = ($countones(v.sel) != 1) || v.serr;
`ifdef APB_TIMEOUT_EN
        if (v.waits >= TO) e = 1'b1;
`endif
        return e;
    endfunction

    // Issue one transfer from IDLE (called at a negedge) and check every
    // cycle until the bridge is back in IDLE.
    task automatic do_txn(input vec_t v);
        bit dec_err, tmo, err, sel_on, in_acc;
        int s, acc, done, e1, fin;
        logic [DW-1:0] exp_rd;
        dec_err = ($countones(v.sel) != 1);
        tmo     = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (v.waits >= TO) tmo = 1'b1;
`endif
        s    = v.wr ? 2 : 1;
        acc  = s + 1;
        done = tmo ? (acc + TO - 1) : (acc + v.waits);
        err  = txn_err(v);
        e1   = dec_err ? 1 : done + 1;
        fin  = err ? e1 + 2 : done + 1;

        valid = 1'b1; Hwrite = v.wr; Haddr = v.addr; Hselx_dec = v.sel;
        Hwdata = v.wdata; Pready = 1'b0; Pslverr = 1'b0; Prdata = $urandom;
        for (int c = 1; c <= fin; c++) begin
            @(negedge Hclk);
            valid = 1'b0; Haddr = $urandom; Hselx_dec = NS'($urandom); Hwrite = 1'($urandom);
            if (c >= 2) Hwdata = $urandom;
            sel_on = !dec_err && (c >= s) && (c <= done);
            in_acc = !dec_err && (c >= acc) && (c <= done);
            exp_rd = (c == fin) ? v.exp_hrdata : m_hrdata;
            chk("Pselx",     64'(Pselx),     sel_on ? 64'(v.sel) : 64'd0);
            chk("Penable",   64'(Penable),   64'(in_acc));
            chk("Hreadyout", 64'(Hreadyout), 64'((c == fin) || (err && c == e1 + 1)));
            chk("Hresp",     64'(Hresp),     64'(err && (c == e1 || c == e1 + 1)));
            chk("Hrdata",    64'(Hrdata),    64'(exp_rd));
            if (sel_on) begin
                chk("Paddr",  64'(Paddr),  64'(v.addr));
                chk("Pwrite", 64'(Pwrite), 64'(v.wr));
                if (v.wr) chk("Pwdata", 64'(Pwdata), 64'(v.wdata));
            end
            if (in_acc) begin
                Pready  = ((c - acc) >= v.waits);
                Pslverr = Pready ? v.serr : 1'($urandom);
                Prdata  = Pready ? v.rdata : $urandom;
            end else begin
                Pready  = 1'($urandom);
                Pslverr = 1'($urandom);
                Prdata  = $urandom;
            end
        end
        m_hrdata = v.exp_hrdata;
        Pready = 1'b0; Pslverr = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        vec_t rv;
        int   r;

        Hresetn = 1'b0; valid = 1'b0; Haddr = '0; Hwrite = 1'b0; Hwdata = '0;
        Hselx_dec = '0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
        m_hrdata = '0;
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        check_reset("reset");
        Hresetn = 1'b1;
        @(negedge Hclk);

        //        wr    addr            sel     wdata          rdata          waits serr  exp_hrdata
        tbl[0] = '{1'b0, 32'h0000_1004, 3'b010, 32'h0,         32'hCAFE_F00D, 0,    1'b0, 32'hCAFE_F00D};
        tbl[1] = '{1'b1, 32'h0000_0020, 3'b001, 32'h1234_5678, 32'h0,         3,    1'b0, 32'hCAFE_F00D};
        tbl[2] = '{1'b0, 32'h0000_2000, 3'b100, 32'h0,         32'hDEAD_BEEF, 0,    1'b1, 32'hCAFE_F00D};
        tbl[3] = '{1'b0, 32'h0000_3000, 3'b000, 32'h0,         32'h1111_1111, 0,    1'b0, 32'hCAFE_F00D};
        tbl[4] = '{1'b1, 32'h0000_0040, 3'b011, 32'h2222_2222, 32'h0,         0,    1'b0, 32'hCAFE_F00D};
        tbl[5] = '{1'b0, 32'h0000_1008, 3'b001, 32'h0,         32'hA5A5_0001, 3,    1'b0, 32'hA5A5_0001};
`ifdef APB_TIMEOUT_EN
        tbl[6] = '{1'b0, 32'h0000_100C, 3'b010, 32'h0,         32'h5A5A_0002, 4,    1'b0, 32'hA5A5_0001};
        tbl[7] = '{1'b1, 32'h0000_0060, 3'b100, 32'h0BAD_CAFE, 32'h0,         100,  1'b0, 32'hA5A5_0001};
`else
        tbl[6] = '{1'b0, 32'h0000_100C, 3'b010, 32'h0,         32'h5A5A_0002, 4,    1'b0, 32'h5A5A_0002};
        tbl[7] = '{1'b1, 32'h0000_0060, 3'b100, 32'h0BAD_CAFE, 32'h0,         100,  1'b0, 32'h5A5A_0002};
`endif
        for (int i = 0; i < 8; i++) do_txn(tbl[i]);

        // Reset while ACCESS is stalled
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h44; Hselx_dec = 3'b100; Pready = 1'b0;
        @(negedge Hclk);
        valid = 1'b0;
        @(negedge Hclk);
        chk("midrst.Penable_before", 64'(Penable), 64'd1);
        @(negedge Hclk);
        Hresetn = 1'b0;
        @(negedge Hclk);
        check_reset("midrst");
        Hresetn = 1'b1;
        m_hrdata = '0;
        rv = '{1'b0, 32'h0000_1010, 3'b001, 32'h0, 32'h600D_F00D, 1, 1'b0, 32'h600D_F00D};
        do_txn(rv);

        // Randomized transfers against the timeline model
        for (int n = 0; n < 40; n++) begin
            rv.wr    = 1'($urandom);
            rv.addr  = $urandom;
            r        = $urandom_range(0, 5);
            rv.sel   = (r < 3) ? NS'(1 << r) : NS'($urandom_range(0, 7));
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.waits = $urandom_range(0, 6);
            rv.serr  = ($urandom_range(0, 3) == 0);
            rv.exp_hrdata = (!txn_err(rv) && !rv.wr) ? rv.rdata : m_hrdata;
            do_txn(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ahb2apb_bridge_ctrl_p

`default_nettype wire
